des_decrypt_seq: RTL and testbench

DES_DECRYPT_SEQ -- requirements
Module: des_decrypt_seq

---
 rtl/des_decrypt_seq.sv | 214 +++++++++++++++++++++
 tb/tb_des_decrypt_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/des_decrypt_seq.sv
// Iterative DES decryption: one Feistel round per clock, subkeys K16..K1 produced
// on the fly by rotating C/D right, valid/ready handshake on both sides.
module des_decrypt_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:64] ct,
    input  logic [1:64] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:64] pt,
    output logic        busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Permutation tables in FIPS 46-3 bit numbering: out[i] = in[T[i]].
    localparam logic [6:0] IP_T [1:64] = '{
        7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,  7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
        7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,  7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
        7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,  7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7};
    localparam logic [6:0] FP_T [1:64] = '{
        7'd40, 7'd8,  7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32, 7'd39, 7'd7,  7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
        7'd38, 7'd6,  7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30, 7'd37, 7'd5,  7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
        7'd36, 7'd4,  7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28, 7'd35, 7'd3,  7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
        7'd34, 7'd2,  7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26, 7'd33, 7'd1,  7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25};
    localparam logic [6:0] PC1_T [1:56] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4};
    localparam logic [5:0] PC2_T [1:48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32};
    localparam logic [5:0] E_T [1:48] = '{
        6'd32, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,  6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd9,
        6'd8,  6'd9,  6'd10, 6'd11, 6'd12, 6'd13, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
        6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21, 6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25,
        6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29, 6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd1};
    localparam logic [5:0] P_T [1:32] = '{
        6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17, 6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
        6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,  6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25};

    // S-boxes packed row-major (row*16+col), entry 0 in the top nibble.
    localparam logic [255:0] S1 = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    localparam logic [255:0] S2 = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    localparam logic [255:0] S3 = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    localparam logic [255:0] S4 = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    localparam logic [255:0] S5 = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    localparam logic [255:0] S6 = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    localparam logic [255:0] S7 = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    localparam logic [255:0] S8 = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

    function automatic logic [1:64] perm_ip(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 1; i <= 64; i++) y[i] = x[IP_T[i]];
        return y;
    endfunction

    function automatic logic [1:64] perm_fp(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 1; i <= 64; i++) y[i] = x[FP_T[i]];
        return y;
    endfunction

    function automatic logic [1:56] perm_pc1(input logic [1:64] x);
        logic [1:56] y;
        for (int i = 1; i <= 56; i++) y[i] = x[PC1_T[i]];
        return y;
    endfunction

    function automatic logic [1:48] perm_pc2(input logic [1:56] x);
        logic [1:48] y;
        for (int i = 1; i <= 48; i++) y[i] = x[PC2_T[i]];
        return y;
    endfunction

    function automatic logic [3:0] sbox(input logic [2:0] n, input logic [5:0] v);
        logic [255:0] t;
        logic [5:0]   idx;
        case (n)
            3'd0:    t = S1;
            3'd1:    t = S2;
            3'd2:    t = S3;
            3'd3:    t = S4;
            3'd4:    t = S5;
            3'd5:    t = S6;
            3'd6:    t = S7;
            default: t = S8;
        endcase
        idx = {v[5], v[0], v[4:1]};
        return t[(8'd252 - {idx, 2'b00}) +: 4];
    endfunction

    function automatic logic [1:32] f_func(input logic [1:32] r, input logic [1:48] k);
        logic [1:48] x;
        logic [1:32] s;
        logic [1:32] y;
        for (int i = 1; i <= 48; i++) x[i] = r[E_T[i]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) s[4*b+1 +: 4] = sbox(3'(b), x[6*b+1 +: 6]);
        for (int i = 1; i <= 32; i++) y[i] = s[P_T[i]];
        return y;
    endfunction

    function automatic logic [1:56] rotr_cd(input logic [1:56] cd, input logic two);
        logic [1:28] c;
        logic [1:28] d;
        c = cd[1:28];
        d = cd[29:56];
        if (two) begin
            c = {c[27:28], c[1:26]};
            d = {d[27:28], d[1:26]};
        end else begin
            c = {c[28], c[1:27]};
            d = {d[28], d[1:27]};
        end
        return {c, d};
    endfunction

    logic [1:0]  state_r;
    logic [1:32] l_r;
    logic [1:32] r_r;
    logic [1:56] cd_r;
    logic [4:0]  j_r;
    logic [1:64] pt_r;
    logic        out_valid_r;
    logic        in_ready_r;
    logic        busy_r;

    logic [1:56] cd_use_s;
    logic [1:32] r_next_s;

    // Round j uses C/D as loaded for j=1, otherwise rotated right by s(18-j).
    always_comb begin
        cd_use_s = cd_r;
        if (j_r == 5'd1) begin
            cd_use_s = cd_r;
        end else if ((j_r == 5'd2) || (j_r == 5'd9) || (j_r == 5'd16)) begin
            cd_use_s = rotr_cd(cd_r, 1'b0);
        end else begin
            cd_use_s = rotr_cd(cd_r, 1'b1);
        end
        r_next_s = l_r ^ f_func(r_r, perm_pc2(cd_use_s));
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            l_r         <= 32'h0;
            r_r         <= 32'h0;
            cd_r        <= 56'h0;
            j_r         <= 5'd0;
            pt_r        <= 64'h0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        {l_r, r_r} <= perm_ip(ct);
                        cd_r       <= perm_pc1(key);
                        j_r        <= 5'd1;
                        state_r    <= ROUND;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                ROUND: begin
                    l_r  <= r_r;
                    r_r  <= r_next_s;
                    cd_r <= cd_use_s;
                    if (j_r == 5'd16) begin
                        // Final swap: preoutput is R16 || L16.
                        pt_r        <= perm_fp({r_next_s, r_r});
                        out_valid_r <= 1'b1;
                        j_r         <= 5'd0;
                        state_r     <= DONE;
                    end else begin
                        j_r <= j_r + 5'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign pt        = pt_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_des_decrypt_seq.sv
// Self-checking bench for des_decrypt_seq: known-answer vectors, backpressure,
// back-to-back, mid-round reset and random vectors against a DES reference model.
module tb_des_decrypt_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:64] ct;
    logic [1:64] key;
    logic        out_valid;
    logic        out_ready;
    logic [1:64] pt;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    des_decrypt_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ct(ct), .key(key),
        .out_valid(out_valid), .out_ready(out_ready), .pt(pt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference tables; the final permutation is derived as the inverse of IP.
    int ip_t [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                      57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    int fp_t [64];
    int pc1_t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                       63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    int pc2_t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                       41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int e_t [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                     16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    int p_t [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    int shifts [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    logic [255:0] sb [8] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

    function automatic logic [1:32] ref_f(input logic [1:32] r, input logic [1:48] k);
        logic [1:48] x;
        logic [1:32] s;
        logic [1:32] y;
        logic [5:0]  v;
        int          idx;
        for (int i = 0; i < 48; i++) x[i+1] = r[e_t[i]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            v   = x[6*b+1 +: 6];
            idx = (v[5] * 2 + v[0]) * 16 + int'(v[4:1]);
            s[4*b+1 +: 4] = sb[b][(255 - 4*idx) -: 4];
        end
        for (int i = 0; i < 32; i++) y[i+1] = s[p_t[i]];
        return y;
    endfunction

    // Textbook decryption: forward key schedule, subkeys applied in reverse.
    function automatic logic [1:64] des_ref(input logic [1:64] k, input logic [1:64] c);
        logic [1:56] cd;
        logic [1:28] cc;
        logic [1:28] dd;
        logic [1:48] ks [1:16];
        logic [1:64] x;
        logic [1:64] y;
        logic [1:32] l;
        logic [1:32] r;
        logic [1:32] t;
        for (int i = 0; i < 56; i++) cd[i+1] = k[pc1_t[i]];
        cc = cd[1:28];
        dd = cd[29:56];
        for (int rd = 1; rd <= 16; rd++) begin
            for (int s = 0; s < shifts[rd-1]; s++) begin
                cc = {cc[2:28], cc[1]};
                dd = {dd[2:28], dd[1]};
            end
            cd = {cc, dd};
            for (int i = 0; i < 48; i++) ks[rd][i+1] = cd[pc2_t[i]];
        end
        for (int i = 0; i < 64; i++) x[i+1] = c[ip_t[i]];
        l = x[1:32];
        r = x[33:64];
        for (int rd = 16; rd >= 1; rd--) begin
            t = r;
            r = l ^ ref_f(r, ks[rd]);
            l = t;
        end
        x = {r, l};
        for (int i = 0; i < 64; i++) y[i+1] = x[fp_t[i]];
        return y;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Accept one block, scramble ct/key during rounds, return once out_valid is seen.
    task automatic run_op(input logic [1:64] k, input logic [1:64] c, input logic [1:64] exp, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_ready"}, 64'(in_ready), 64'd1);
        key = k;
        ct = c;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq({tag, "_busy"}, {62'd0, busy, in_ready}, 64'd2);
        n = 0;
        while (!out_valid && n < 40) begin
            key = {$urandom, $urandom};
            ct = {$urandom, $urandom};
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_lat"}, 64'(n), 64'd16);
        check_eq({tag, "_pt"}, pt, exp);
    endtask

    task automatic expect_handshake(input string tag);
        @(posedge clk); #1;
        check_eq({tag, "_hs"}, {61'd0, out_valid, in_ready, busy}, 64'd2);
    endtask

    initial begin
        logic [1:64] rk;
        logic [1:64] rc;
        logic [1:64] rexp;
        for (int i = 0; i < 64; i++) fp_t[ip_t[i]-1] = i + 1;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        ct = 64'h0;
        key = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset", {pt, out_valid, in_ready, busy}, {64'h0, 3'b010});
        @(negedge clk);
        rst = 1'b0;

        run_op(64'h22234512987ABB23, 64'h0A4ED5C15A63FEA3, 64'h0000000000000001, "kat1");
        expect_handshake("kat1");
        run_op(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, "kat2");
        expect_handshake("kat2");

        // Same key with every parity bit flipped, then held in DONE by backpressure.
        out_ready = 1'b0;
        run_op(64'h133457799BBCDFF1 ^ 64'h0101010101010101, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, "par");
        for (int w = 0; w < 10; w++) begin
            in_valid = (w == 3);
            ct = 64'h0A4ED5C15A63FEA3;
            @(posedge clk); #1;
            check_eq("bp_hold", {pt, out_valid, in_ready, busy}, {64'h0123456789ABCDEF, 3'b101});
        end
        // Release with a new request pending: only the output handshake may happen.
        out_ready = 1'b1;
        in_valid = 1'b1;
        key = 64'h0101010101010101;
        ct = 64'h8CA64DE9C1B123A7;
        expect_handshake("bp");
        run_op(64'h0101010101010101, 64'h8CA64DE9C1B123A7, 64'h0000000000000000, "weak");
        expect_handshake("weak");

        for (int t = 0; t < 6; t++) begin
            rk = {$urandom, $urandom};
            rc = {$urandom, $urandom};
            rexp = des_ref(rk, rc);
            out_ready = 1'($urandom_range(0, 1));
            run_op(rk, rc, rexp, "rand");
            if (!out_ready) begin
                repeat ($urandom_range(1, 4)) begin
                    @(posedge clk); #1;
                    check_eq("rand_hold", {pt, out_valid}, {rexp, 1'b1});
                end
                out_ready = 1'b1;
            end
            expect_handshake("rand");
        end

        // Abort in round 8, then immediately start a fresh block on release.
        key = 64'h22234512987ABB23;
        ct = 64'h0A4ED5C15A63FEA3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort_async", {pt, out_valid, in_ready, busy}, {64'h0, 3'b010});
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            check_eq("abort_hold", {pt, out_valid, in_ready, busy}, {64'h0, 3'b010});
        end
        rst = 1'b0;
        run_op(64'h22234512987ABB23, 64'h0A4ED5C15A63FEA3, 64'h0000000000000001, "post_rst");
        expect_handshake("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
